// File: rtl/sdram_init_param.sv
// sdram_init_param: SDRAM power-up initialisation sequencer.
//
// Sequence after enable is sampled high in Idle:
//   PowerUp (T_DELAY NOPs) -> PALL -> T_RP NOPs -> N_REF x (REF, T_RC NOPs)
//   -> MRS -> T_MRD NOPs -> [EMRS -> T_MRD NOPs] -> Done -> Idle
//
// Optional feature: define SDRAM_INIT_EMRS_EN to add the extended mode-register
// write (EMRS, bank 2'b10, address 0) after the MRS wait.
//
// Ports:
//   clock      in   single clock for all state
//   reset      in   asynchronous, active-high
//   enable     in   level; starts the sequence when sampled high in Idle
//   busy       out  high in every state except Idle
//   end_init   out  one-cycle pulse while in Done
//   init_done  out  sticky; set on the edge leaving Done, cleared on re-init
//   dram_addr  out  SDRAM address bus (ADDR_W bits, ADDR_W >= 11)
//   dram_ba    out  SDRAM bank address
//   dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n  out  SDRAM command pins
//
// All timing parameters must be at least 1.
module sdram_init_param #(
   parameter int unsigned T_DELAY     = 20000,
   parameter int unsigned T_RP        = 2,
   parameter int unsigned T_RC        = 9,
   parameter int unsigned N_REF       = 8,
   parameter int unsigned T_MRD       = 2,
   parameter int unsigned CAS_LATENCY = 3,
   parameter int unsigned BURST_LEN   = 0,
   parameter int unsigned BURST_TYPE  = 0,
   parameter int unsigned WB_SINGLE   = 1,
   parameter int unsigned ADDR_W      = 13
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   output logic              busy,
   output logic              end_init,
   output logic              init_done,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [1:0]        dram_ba,
   output logic              dram_cs_n,
   output logic              dram_ras_n,
   output logic              dram_cas_n,
   output logic              dram_we_n
);

   localparam int unsigned T_MAX_A = (T_DELAY > T_RP) ? T_DELAY : T_RP;
   localparam int unsigned T_MAX_B = (T_RC > T_MRD) ? T_RC : T_MRD;
   localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int unsigned CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   // Terminal counts: a wait of T cycles ends when the counter reads T-1.
   localparam logic [CNT_W-1:0] T_DELAY_LAST = CNT_W'(T_DELAY - 1);
   localparam logic [CNT_W-1:0] T_RP_LAST    = CNT_W'(T_RP - 1);
   localparam logic [CNT_W-1:0] T_RC_LAST    = CNT_W'(T_RC - 1);
   localparam logic [CNT_W-1:0] T_MRD_LAST   = CNT_W'(T_MRD - 1);
   localparam logic [7:0]       N_REF_8      = 8'(N_REF);

   // Mode word: A9 write-burst mode, A6:4 CAS latency, A3 burst type, A2:0 burst length.
   localparam logic [9:0] MODE_WORD = {1'(WB_SINGLE), 2'b00, 3'(CAS_LATENCY),
                                       1'(BURST_TYPE), 3'(BURST_LEN)};

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PALL = 4'b0010;
   localparam logic [3:0] CMD_REF  = 4'b0001;
   localparam logic [3:0] CMD_MRS  = 4'b0000;

   typedef enum logic [3:0] {
      StIdle     = 4'd0,
      StPowerUp  = 4'd1,
      StPall     = 4'd2,
      StWaitRp   = 4'd3,
      StAutoRef  = 4'd4,
      StWaitRc   = 4'd5,
      StModeReg  = 4'd6,
      StWaitMrd  = 4'd7,
      StDone     = 4'd8
`ifdef SDRAM_INIT_EMRS_EN
      ,
      StEmrs     = 4'd9,
      StWaitEmrs = 4'd10
`endif
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       ref_cnt;
   logic [3:0]       cmd;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= StIdle;
         cnt       <= '0;
         ref_cnt   <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (enable) begin
                  // Fresh start: a re-init always runs the complete sequence.
                  state     <= StPowerUp;
                  cnt       <= '0;
                  ref_cnt   <= '0;
                  init_done <= 1'b0;
               end
            end
            StPowerUp: begin
               if (cnt == T_DELAY_LAST) begin
                  state <= StPall;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            StPall: begin
               state <= StWaitRp;
               cnt   <= '0;
            end
            StWaitRp: begin
               if (cnt == T_RP_LAST) begin
                  state <= StAutoRef;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            StAutoRef: begin
               state   <= StWaitRc;
               cnt     <= '0;
               ref_cnt <= ref_cnt + 8'd1;
            end
            StWaitRc: begin
               if (cnt == T_RC_LAST) begin
                  state <= (ref_cnt < N_REF_8) ? StAutoRef : StModeReg;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            StModeReg: begin
               state <= StWaitMrd;
               cnt   <= '0;
            end
            StWaitMrd: begin
               if (cnt == T_MRD_LAST) begin
`ifdef SDRAM_INIT_EMRS_EN
                  state <= StEmrs;
`else
                  state <= StDone;
`endif
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`ifdef SDRAM_INIT_EMRS_EN
            StEmrs: begin
               state <= StWaitEmrs;
               cnt   <= '0;
            end
            StWaitEmrs: begin
               if (cnt == T_MRD_LAST) begin
                  state <= StDone;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`endif
            StDone: begin
               state     <= StIdle;
               cnt       <= '0;
               init_done <= 1'b1;
            end
            default: begin
               state <= StIdle;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Outputs are a pure decode of the state register.
   always_comb begin
      cmd       = CMD_NOP;
      dram_addr = '0;
      dram_ba   = 2'b00;
      busy      = 1'b1;
      end_init  = 1'b0;
      case (state)
         StIdle: busy = 1'b0;
         StPall: begin
            cmd           = CMD_PALL;
            dram_addr[10] = 1'b1;
         end
         StAutoRef: cmd = CMD_REF;
         StModeReg: begin
            cmd       = CMD_MRS;
            dram_addr = {{(ADDR_W - 10){1'b0}}, MODE_WORD};
         end
`ifdef SDRAM_INIT_EMRS_EN
         StEmrs: begin
            cmd     = CMD_MRS;
            dram_ba = 2'b10;
         end
`endif
         StDone: end_init = 1'b1;
         default: cmd = CMD_NOP;
      endcase
   end

   assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = cmd;

endmodule

// File: tb/tb_sdram_init_param.sv
// Bench for sdram_init_param: two instances (N_REF = 2 and N_REF = 1) driven by
// the same directed and random enable/reset stimulus, each compared every cycle
// against a timeline model of the command sequence.
module tb_sdram_init_param;

   localparam int TD = 10, TRP = 2, TRC = 3, TMRD = 2;
   localparam logic [3:0] NOP = 4'b0111, PALL = 4'b0010, REF = 4'b0001, MRS = 4'b0000;
`ifdef SDRAM_INIT_EMRS_EN
   localparam bit EMRS = 1'b1;
   localparam int DONE_T = 28;
`else
   localparam bit EMRS = 1'b0;
   localparam int DONE_T = 25;
`endif

   typedef struct packed {
      logic [3:0]  cmd;
      logic [12:0] addr;
      logic [1:0]  ba;
      logic        busy;
      logic        end_init;
      logic        init_done;
   } obs_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;
   always #5 clock = ~clock;

   logic busy0, end0, idn0, cs0, ras0, cas0, we0;
   logic busy1, end1, idn1, cs1, ras1, cas1, we1;
   logic [12:0] addr0, addr1;
   logic [1:0]  ba0, ba1;

   sdram_init_param #(
      .T_DELAY(TD), .T_RP(TRP), .T_RC(TRC), .N_REF(2), .T_MRD(TMRD),
      .CAS_LATENCY(2), .BURST_LEN(3), .BURST_TYPE(1), .WB_SINGLE(0), .ADDR_W(13)
   ) dut0 (
      .clock(clock), .reset(reset), .enable(enable), .busy(busy0), .end_init(end0),
      .init_done(idn0), .dram_addr(addr0), .dram_ba(ba0), .dram_cs_n(cs0),
      .dram_ras_n(ras0), .dram_cas_n(cas0), .dram_we_n(we0)
   );

   sdram_init_param #(
      .T_DELAY(TD), .T_RP(TRP), .T_RC(TRC), .N_REF(1), .T_MRD(TMRD),
      .CAS_LATENCY(2), .BURST_LEN(3), .BURST_TYPE(1), .WB_SINGLE(0), .ADDR_W(13)
   ) dut1 (
      .clock(clock), .reset(reset), .enable(enable), .busy(busy1), .end_init(end1),
      .init_done(idn1), .dram_addr(addr1), .dram_ba(ba1), .dram_cs_n(cs1),
      .dram_ras_n(ras1), .dram_cas_n(cas1), .dram_we_n(we1)
   );

   obs_t obs0, obs1;
   assign obs0 = {cs0, ras0, cas0, we0, addr0, ba0, busy0, end0, idn0};
   assign obs1 = {cs1, ras1, cas1, we1, addr1, ba1, busy1, end1, idn1};

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit cmp_en = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- timeline model ----------------
   // k = 0 means idle; k = n means the n-th cycle after enable was sampled.
   function automatic int t_pall();
      return TD + 1;
   endfunction
   function automatic int t_ref(int i);
      return t_pall() + 1 + TRP + i * (TRC + 1);
   endfunction
   function automatic int t_mrs(int nref);
      return t_ref(nref);
   endfunction
   function automatic int t_emrs(int nref);
      return t_mrs(nref) + 1 + TMRD;
   endfunction
   function automatic int t_done(int nref);
      return (EMRS ? t_emrs(nref) : t_mrs(nref)) + 1 + TMRD;
   endfunction

   function automatic obs_t expect_out(int k, int nref, logic idone);
      obs_t o;
      o.cmd = NOP; o.addr = '0; o.ba = 2'b00;
      o.busy = (k != 0); o.end_init = 1'b0; o.init_done = idone;
      if (k == t_pall()) begin
         o.cmd = PALL; o.addr = 13'h400;
      end
      for (int i = 0; i < nref; i++) if (k == t_ref(i)) o.cmd = REF;
      if (k == t_mrs(nref)) begin
         o.cmd = MRS; o.addr = 13'h02B;
      end
      if (EMRS && k == t_emrs(nref)) begin
         o.cmd = MRS; o.ba = 2'b10;
      end
      if (k == t_done(nref)) o.end_init = 1'b1;
      return o;
   endfunction

   function automatic int next_k(int k, logic en, int nref);
      if (k == 0) return en ? 1 : 0;
      if (k == t_done(nref)) return 0;
      return k + 1;
   endfunction

   function automatic logic next_id(int k, logic id, logic en);
      if (k == 0) return en ? 1'b0 : id;
      if (k == t_done(1) || k == t_done(2)) return id;
      return id;
   endfunction

   function automatic logic next_idn(int k, logic id, logic en, int nref);
      if (k == 0 && en) return 1'b0;
      if (k != 0 && k == t_done(nref)) return 1'b1;
      return id;
   endfunction

   int   k0 = 0, k1 = 0;
   logic m_id0 = 1'b0, m_id1 = 1'b0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         k0 <= 0; k1 <= 0; m_id0 <= 1'b0; m_id1 <= 1'b0;
      end else begin
         k0    <= next_k(k0, enable, 2);
         k1    <= next_k(k1, enable, 1);
         m_id0 <= next_idn(k0, m_id0, enable, 2);
         m_id1 <= next_idn(k1, m_id1, enable, 1);
      end
   end

   task automatic check_obs(string name, obs_t act, obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got cmd=%b addr=%h ba=%b busy=%b end=%b done=%b, want cmd=%b addr=%h ba=%b busy=%b end=%b done=%b",
                  name, $time, act.cmd, act.addr, act.ba, act.busy, act.end_init, act.init_done,
                  exp.cmd, exp.addr, exp.ba, exp.busy, exp.end_init, exp.init_done);
      end
   endtask

   task automatic check_val(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Per-cycle compare; inputs change 1 time unit after the negedge.
   always @(negedge clock) begin
      if (cmp_en) begin
         check_obs("dut0_model", obs0, expect_out(k0, 2, m_id0));
         check_obs("dut1_model", obs1, expect_out(k1, 1, m_id1));
      end
   end

   // ---------------- directed sequences ----------------
   task automatic run_timed();
      int t0, rel;
      int pall_t = -1, mrs_t = -1, emrs_t = -1, end_t = -1, idle_t = -1, mrs1_t = -1;
      int nref0 = 0, nref1 = 0, done_hi = -1;
      int ref_t[2] = '{-1, -1};
      int pall_a = 0, mrs_a = 0, emrs_b = 0;
      @(negedge clock); #1 enable = 1'b1; t0 = cyc;
      for (int i = 0; i < DONE_T + 6; i++) begin
         @(negedge clock);
         rel = cyc - t0;
         if ({cs0, ras0, cas0, we0} == PALL && pall_t < 0) begin
            pall_t = rel; pall_a = int'(addr0);
         end
         if ({cs0, ras0, cas0, we0} == REF) begin
            if (nref0 < 2) ref_t[nref0] = rel;
            nref0++;
         end
         if ({cs0, ras0, cas0, we0} == MRS && ba0 == 2'b00 && mrs_t < 0) begin
            mrs_t = rel; mrs_a = int'(addr0);
         end
         if ({cs0, ras0, cas0, we0} == MRS && ba0 != 2'b00 && emrs_t < 0) begin
            emrs_t = rel; emrs_b = int'(ba0);
         end
         if (end0 && end_t < 0) end_t = rel;
         if (!busy0 && idle_t < 0) idle_t = rel;
         if (rel == DONE_T + 1) done_hi = int'(idn0);
         if ({cs1, ras1, cas1, we1} == REF) nref1++;
         if ({cs1, ras1, cas1, we1} == MRS && ba1 == 2'b00 && mrs1_t < 0) mrs1_t = rel;
         if (i == 0) #1 enable = 1'b0;
      end
      check_val("pall_cycle", pall_t, 11);
      check_val("pall_addr", pall_a, 'h400);
      check_val("ref_count", nref0, 2);
      check_val("ref0_cycle", ref_t[0], 14);
      check_val("ref1_cycle", ref_t[1], 18);
      check_val("mrs_cycle", mrs_t, 22);
      check_val("mrs_addr", mrs_a, 'h02B);
      check_val("end_init_cycle", end_t, DONE_T);
      check_val("busy_low_cycle", idle_t, DONE_T + 1);
      check_val("init_done_after", done_hi, 1);
      check_val("nref1_ref_count", nref1, 1);
      check_val("nref1_mrs_cycle", mrs1_t, 18);
`ifdef SDRAM_INIT_EMRS_EN
      check_val("emrs_cycle", emrs_t, 25);
      check_val("emrs_ba", emrs_b, 2);
`else
      check_val("no_emrs", emrs_t, -1);
`endif
   endtask

   initial begin
      int t0, rel;
      @(negedge clock); #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      cmp_en = 1'b1;
      check_val("reset_busy", int'(busy0), 0);
      check_val("reset_cmd", int'({cs0, ras0, cas0, we0}), int'(NOP));
      check_val("reset_init_done", int'(idn0), 0);
      #1 reset = 1'b0;
      repeat (3) @(negedge clock);

      run_timed();

      // Reset in the middle of WaitRc aborts at once.
      @(negedge clock); #1 enable = 1'b1; t0 = cyc;
      @(negedge clock); #1 enable = 1'b0;
      for (int i = 0; i < 40 && (cyc - t0) < 16; i++) @(negedge clock);
      #1 reset = 1'b1;
      #1;
      check_val("midrst_busy0", int'(busy0), 0);
      check_val("midrst_cmd0", int'({cs0, ras0, cas0, we0}), int'(NOP));
      check_val("midrst_busy1", int'(busy1), 0);
      check_val("midrst_addr0", int'(addr0), 0);
      @(negedge clock); #1 reset = 1'b0;
      @(negedge clock);
      run_timed();

      // Enable held high: back-to-back sequences.
      @(negedge clock); #1 enable = 1'b1; t0 = cyc;
      for (int i = 0; i < 2 * (DONE_T + 1) + 4; i++) begin
         @(negedge clock);
         rel = cyc - t0;
         if (rel == DONE_T + 1) begin
            check_val("hold_done_hi", int'(idn0), 1);
            check_val("hold_idle", int'(busy0), 0);
         end
         if (rel == DONE_T + 2) begin
            check_val("hold_done_lo", int'(idn0), 0);
            check_val("hold_restart", int'(busy0), 1);
         end
         if (rel == 2 * DONE_T + 2) check_val("hold_done_hi2", int'(idn0), 1);
      end
      #1 enable = 1'b0;
      repeat (2 * (DONE_T + 2)) @(negedge clock);

      // Random enable / occasional reset, checked by the model every cycle.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clock);
         #1;
         enable = ($urandom_range(0, 3) == 0);
         reset  = ($urandom_range(0, 149) == 0);
      end
      #1 reset = 1'b0; enable = 1'b0;
      repeat (2 * (DONE_T + 2)) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
